// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: timing defaults, command pin encodings, decoded
// command codes and checker FSM states.
package ddr2_pkg;

  localparam int T_RP_DEFAULT       = 3;
  localparam int T_RFC_DEFAULT      = 26;
  localparam int T_MRD_DEFAULT      = 2;
  localparam int T_REFI_MAX_DEFAULT = 1560;

  // {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    PIN_MRS  = 4'b0000,
    PIN_AREF = 4'b0001,
    PIN_PRE  = 4'b0010,
    PIN_ACT  = 4'b0011,
    PIN_WR   = 4'b0100,
    PIN_RD   = 4'b0101,
    PIN_RSVD = 4'b0110,
    PIN_NOP  = 4'b0111
  } pin_cmd_e;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4,
    CMD_PREA = 3'd5,
    CMD_AREF = 3'd6,
    CMD_MRS  = 3'd7
  } cmd_code_e;

  typedef enum logic [1:0] {
    ST_PWRUP   = 2'd0,
    ST_READY   = 2'd1,
    ST_REFRESH = 2'd2,
    ST_MRD     = 2'd3
  } state_e;

  // Deselect, explicit NOP and the reserved encoding all decode as NOP.
  function automatic cmd_code_e decode_cmd(input logic [3:0] pins, input logic a10);
    cmd_code_e c;
    c = CMD_NOP;
    case (pins)
      PIN_ACT:  c = CMD_ACT;
      PIN_RD:   c = CMD_RD;
      PIN_WR:   c = CMD_WR;
      PIN_PRE:  c = a10 ? CMD_PREA : CMD_PRE;
      PIN_AREF: c = CMD_AREF;
      PIN_MRS:  c = CMD_MRS;
      default:  c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ddr2_bank_timer.sv
// Per-bank precharge timer: reloads on PRE/PREA and reports busy until the
// tRP window has elapsed.
module ddr2_bank_timer #(
  parameter int T_RP = 3
) (
  input  logic ck,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int W = (T_RP > 1) ? $clog2(T_RP) : 1;

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= W'(T_RP - 1);
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/ddr2_cmd_checker.sv
// DDR2 command-bus protocol checker: decodes commands, tracks bank and mode
// register state, and raises sticky flags on timing or sequencing violations.
module ddr2_cmd_checker
  import ddr2_pkg::*;
#(
  parameter int BA_BITS    = 3,
  parameter int ADDR_BITS  = 13,
  parameter int T_RP       = T_RP_DEFAULT,
  parameter int T_RFC      = T_RFC_DEFAULT,
  parameter int T_MRD      = T_MRD_DEFAULT,
  parameter int T_REFI_MAX = T_REFI_MAX_DEFAULT
) (
  input  logic                    ck,
  input  logic                    rst_n,
  input  logic                    cke,
  input  logic                    cs_n,
  input  logic                    ras_n,
  input  logic                    cas_n,
  input  logic                    we_n,
  input  logic [BA_BITS-1:0]      ba,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic                    err_clr,
  output logic                    cmd_valid,
  output logic [2:0]              cmd_code,
  output logic [(1<<BA_BITS)-1:0] bank_open,
  output logic [ADDR_BITS-1:0]    mr_value,
  output logic [ADDR_BITS-1:0]    emr_value,
  output logic [15:0]             aref_count,
  output logic                    err_trp,
  output logic                    err_trfc,
  output logic                    err_tmrd,
  output logic                    err_trefi,
  output logic                    err_illegal
);

  localparam int NB      = 1 << BA_BITS;
  localparam int CNT_MAX = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REFI_W  = $clog2(T_REFI_MAX + 1);

  logic [3:0] pins;
  cmd_code_e  cmd;
  logic       is_cmd;
  logic       rsvd;

  assign pins = {cs_n, ras_n, cas_n, we_n};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cmd  = CMD_NOP;
    rsvd = 1'b0;
    if (cke) begin
      cmd  = decode_cmd(pins, addr[10]);
      rsvd = (pins == PIN_RSVD);
    end
  end

  assign is_cmd = (cmd != CMD_NOP);

  logic [NB-1:0] bank_load;
  logic [NB-1:0] bank_busy;

  for (genvar g = 0; g < NB; g++) begin : g_bank
    assign bank_load[g] = (cmd == CMD_PREA) || ((cmd == CMD_PRE) && (ba == BA_BITS'(g)));
    ddr2_bank_timer #(.T_RP(T_RP)) u_timer (
      .ck    (ck),
      .rst_n (rst_n),
      .load  (bank_load[g]),
      .busy  (bank_busy[g])
    );
  end

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             load_rfc, load_mrd;
  logic             viol_trfc, viol_tmrd, viol_pwrup;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= ST_PWRUP;
    else        state <= state_nxt;
  end

  // Leave REFRESH/MRD on the edge where the countdown reaches zero.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRUP:   if (cmd == CMD_PREA) state_nxt = ST_READY;
      ST_READY: begin
        if (cmd == CMD_AREF)     state_nxt = ST_REFRESH;
        else if (cmd == CMD_MRS) state_nxt = ST_MRD;
      end
      ST_REFRESH,
      ST_MRD:     if (cnt <= CNT_W'(1)) state_nxt = ST_READY;
      default:    state_nxt = ST_PWRUP;
    endcase
  end

  always_comb begin
    load_rfc   = (state == ST_READY) && (cmd == CMD_AREF);
    load_mrd   = (state == ST_READY) && (cmd == CMD_MRS);
    viol_trfc  = (state == ST_REFRESH) && is_cmd;
    viol_tmrd  = (state == ST_MRD) && is_cmd;
    viol_pwrup = (state == ST_PWRUP) && is_cmd && (cmd != CMD_PREA);
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load_rfc)    cnt <= CNT_W'(T_RFC - 1);
    else if (load_mrd)    cnt <= CNT_W'(T_MRD - 1);
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  // Refresh-interval watchdog: idle until the first AREF, then saturates at the limit.
  logic              refi_run;
  logic [REFI_W-1:0] refi_cnt;
  logic              refi_hit;

  assign refi_hit = refi_run && (cmd != CMD_AREF) && (refi_cnt == REFI_W'(T_REFI_MAX - 1));

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      refi_run <= 1'b0;
      refi_cnt <= '0;
    end else if (cmd == CMD_AREF) begin
      refi_run <= 1'b1;
      refi_cnt <= '0;
    end else if (refi_run && (refi_cnt != REFI_W'(T_REFI_MAX))) begin
      refi_cnt <= refi_cnt + 1'b1;
    end
  end

  logic set_trp, set_illegal;

  always_comb begin
    set_trp     = ((cmd == CMD_ACT) && bank_busy[ba]) ||
                  ((cmd == CMD_AREF) && (|bank_busy));
    set_illegal = rsvd || viol_pwrup ||
                  ((cmd == CMD_ACT) && bank_open[ba]) ||
                  (((cmd == CMD_RD) || (cmd == CMD_WR)) && !bank_open[ba]) ||
                  (((cmd == CMD_AREF) || (cmd == CMD_MRS)) && (|bank_open));
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= CMD_NOP;
      bank_open   <= '0;
      mr_value    <= '0;
      emr_value   <= '0;
      aref_count  <= '0;
      err_trp     <= 1'b0;
      err_trfc    <= 1'b0;
      err_tmrd    <= 1'b0;
      err_trefi   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      cmd_valid <= is_cmd;
      cmd_code  <= cmd;
      case (cmd)
        CMD_ACT:  bank_open[ba] <= 1'b1;
        CMD_PRE:  bank_open[ba] <= 1'b0;
        CMD_PREA: bank_open     <= '0;
        CMD_AREF: aref_count    <= aref_count + 16'd1;
        CMD_MRS: begin
          if (ba == BA_BITS'(0))      mr_value  <= addr;
          else if (ba == BA_BITS'(1)) emr_value <= addr;
        end
        default: ;
      endcase
      // A new error on the clearing edge wins over err_clr.
      err_trp     <= set_trp     | (err_trp     & ~err_clr);
      err_trfc    <= viol_trfc   | (err_trfc    & ~err_clr);
      err_tmrd    <= viol_tmrd   | (err_tmrd    & ~err_clr);
      err_trefi   <= refi_hit    | (err_trefi   & ~err_clr);
      err_illegal <= set_illegal | (err_illegal & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ddr2_cmd_checker.sv
// Self-checking bench for ddr2_cmd_checker: per-cycle command scoreboard plus
// directed protocol scenarios with default parameters.
module tb_ddr2_cmd_checker;

  localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4,
                 C_PREA = 5, C_AREF = 6, C_MRS = 7, C_RSVD = 8;

  localparam logic [4:0] E_NONE  = 5'b00000;
  localparam logic [4:0] E_TRP   = 5'b10000;
  localparam logic [4:0] E_TRFC  = 5'b01000;
  localparam logic [4:0] E_TMRD  = 5'b00100;
  localparam logic [4:0] E_TREFI = 5'b00010;
  localparam logic [4:0] E_ILL   = 5'b00001;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        cke;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [12:0] addr;
  logic        err_clr;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [7:0]  bank_open;
  logic [12:0] mr_value, emr_value;
  logic [15:0] aref_count;
  logic        err_trp, err_trfc, err_tmrd, err_trefi, err_illegal;
  logic [4:0]  errs;

  assign errs = {err_trp, err_trfc, err_tmrd, err_trefi, err_illegal};

  ddr2_cmd_checker dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .cke         (cke),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .addr        (addr),
    .err_clr     (err_clr),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .bank_open   (bank_open),
    .mr_value    (mr_value),
    .emr_value   (emr_value),
    .aref_count  (aref_count),
    .err_trp     (err_trp),
    .err_trfc    (err_trfc),
    .err_tmrd    (err_tmrd),
    .err_trefi   (err_trefi),
    .err_illegal (err_illegal)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic       valid;
    logic [2:0] code;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one command for one sampling edge and queue its expected decode.
  task automatic step(input int c, input int b = 0, input int a = 0,
                      input logic k = 1'b1, input logic clr = 1'b0);
    logic [3:0]  p;
    logic [12:0] av;
    av = 13'(a);
    case (c)
      C_ACT:  p = 4'b0011;
      C_RD:   p = 4'b0101;
      C_WR:   p = 4'b0100;
      C_PRE:  begin p = 4'b0010; av[10] = 1'b0; end
      C_PREA: begin p = 4'b0010; av[10] = 1'b1; end
      C_AREF: p = 4'b0001;
      C_MRS:  p = 4'b0000;
      C_RSVD: p = 4'b0110;
      default: p = 4'b0111;
    endcase
    @(negedge ck);
    {cs_n, ras_n, cas_n, we_n} = p;
    ba      = 3'(b);
    addr    = av;
    cke     = k;
    err_clr = clr;
    @(posedge ck);
    sb_q.push_back('{valid: (k && c != C_NOP && c != C_RSVD),
                     code:  (k && c != C_RSVD) ? 3'(c) : 3'd0});
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(C_NOP);
  endtask

  always @(negedge ck) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("sb_cmd_valid", 32'(cmd_valid), 32'(mon_e.valid));
      check("sb_cmd_code",  32'(cmd_code),  32'(mon_e.code));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_valid"},  32'(cmd_valid),  0);
    check({tag, "_cmd_code"},   32'(cmd_code),   0);
    check({tag, "_bank_open"},  32'(bank_open),  0);
    check({tag, "_mr_value"},   32'(mr_value),   0);
    check({tag, "_emr_value"},  32'(emr_value),  0);
    check({tag, "_aref_count"}, 32'(aref_count), 0);
    check({tag, "_errs"},       32'(errs),       32'(E_NONE));
  endtask

  task automatic do_reset();
    @(negedge ck);
    #1;
    rst_n = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = 4'b0111;
    cke     = 1'b1;
    err_clr = 1'b0;
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cke   = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = 4'b1111;
    ba      = '0;
    addr    = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    #1;
    check_reset_vals("por");

    // Anything but PREA during power-up is illegal.
    step(C_ACT, 0);
    check("pwrup_act_errs", 32'(errs), 32'(E_ILL));

    // Legal init, refresh, activate.
    do_reset();
    step(C_PREA);
    check("prea_errs", 32'(errs), 32'(E_NONE));
    idle(2);
    step(C_AREF);
    check("aref_count_1", 32'(aref_count), 1);
    idle(26);
    step(C_ACT, 2);
    check("s1_bank_open", 32'(bank_open), 32'h04);
    check("s1_aref_count", 32'(aref_count), 1);
    check("s1_errs", 32'(errs), 32'(E_NONE));

    // tRP violation: ACT two cycles after PREA.
    do_reset();
    step(C_PREA);
    idle(1);
    step(C_ACT, 0);
    check("trp_errs", 32'(errs), 32'(E_TRP));

    // tRFC violation, then clear.
    do_reset();
    step(C_PREA);
    idle(2);
    step(C_AREF);
    idle(9);
    step(C_ACT, 0);
    check("trfc_errs", 32'(errs), 32'(E_TRFC));
    step(C_NOP, 0, 0, 1'b1, 1'b1);
    check("trfc_clr_errs", 32'(errs), 32'(E_NONE));

    // Bank-state legality, cke gating, reserved encoding, set-beats-clear.
    do_reset();
    step(C_PREA);
    idle(2);
    step(C_ACT, 1);
    check("act1_errs", 32'(errs), 32'(E_NONE));
    step(C_RD, 3);
    check("rd_closed_errs", 32'(errs), 32'(E_ILL));
    step(C_ACT, 1);
    check("act_open_errs", 32'(errs), 32'(E_ILL));
    check("act_open_bank_open", 32'(bank_open), 32'h02);
    step(C_NOP, 0, 0, 1'b1, 1'b1);
    check("ill_clr_errs", 32'(errs), 32'(E_NONE));
    step(C_RD, 1);
    step(C_WR, 1);
    check("rdwr_open_errs", 32'(errs), 32'(E_NONE));
    step(C_RD, 3, 0, 1'b0);
    check("cke_low_errs", 32'(errs), 32'(E_NONE));
    step(C_RSVD);
    check("rsvd_errs", 32'(errs), 32'(E_ILL));
    step(C_NOP, 0, 0, 1'b1, 1'b1);
    check("rsvd_clr_errs", 32'(errs), 32'(E_NONE));
    step(C_ACT, 1, 0, 1'b1, 1'b1);
    check("set_wins_errs", 32'(errs), 32'(E_ILL));
    step(C_PRE, 4);
    check("pre_closed_errs", 32'(errs), 32'(E_ILL));
    step(C_NOP, 0, 0, 1'b1, 1'b1);
    step(C_PRE, 1);
    check("pre_bank_open", 32'(bank_open), 0);
    check("pre_errs", 32'(errs), 32'(E_NONE));

    // Mode registers and tMRD.
    do_reset();
    step(C_PREA);
    idle(2);
    step(C_MRS, 1, 'h0044);
    check("emr_value", 32'(emr_value), 32'h0044);
    idle(1);
    step(C_MRS, 2, 'h1FFF);
    check("mrs_ba2_mr", 32'(mr_value), 0);
    check("mrs_ba2_emr", 32'(emr_value), 32'h0044);
    check("mrs_spacing_errs", 32'(errs), 32'(E_NONE));
    idle(1);
    step(C_MRS, 0, 'h0432);
    check("mr_value", 32'(mr_value), 32'h0432);
    step(C_ACT, 0);
    check("tmrd_errs", 32'(errs), 32'(E_TMRD));

    // Refresh interval limit, then reset during a refresh countdown.
    do_reset();
    step(C_PREA);
    idle(2);
    step(C_AREF);
    idle(1559);
    check("trefi_edge_minus1", 32'(errs), 32'(E_NONE));
    idle(1);
    check("trefi_errs", 32'(errs), 32'(E_TREFI));
    step(C_AREF);
    check("aref_count_2", 32'(aref_count), 2);
    idle(5);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_refresh_rst");
    repeat (2) @(negedge ck);
    rst_n = 1'b1;
    idle(30);
    check("post_rst_errs", 32'(errs), 32'(E_NONE));
    step(C_PREA);
    check("post_rst_prea_errs", 32'(errs), 32'(E_NONE));

    @(negedge ck);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
